// File: rtl/pipe_stage_skid.sv
// Registered pipe stage with one skid entry; in_ready/out_valid from state.
// Ports: clk, rst_n, flush, in_* (valid/ready word), out_* word, occupancy, stall_cnt.
module pipe_stage_skid #(
  parameter int DATA_W = 8,
  parameter int NLANE  = 2,
  parameter int TAG_W  = 4,
  parameter int RA_W   = 2,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NLANE*DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic [RA_W-1:0]         in_ra,
  input  logic [RA_W-1:0]         in_rb,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NLANE*DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]        out_tag,
  output logic [RA_W-1:0]         out_ra,
  output logic [RA_W-1:0]         out_rb,
  output logic [1:0]              occupancy,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam int DW = NLANE * DATA_W;
  localparam int WW = DW + TAG_W + 2 * RA_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [WW-1:0] main_q;
  logic [WW-1:0] skid_q;
  logic [WW-1:0] in_word;
  logic          accept;
  logic          drain;
  logic          ld_main_in;
  logic          ld_main_sk;
  logic          ld_skid;

  assign in_word = {in_data, in_tag, in_ra, in_rb};

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign occupancy = state;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  assign {out_data, out_tag, out_ra, out_rb} = main_q;

  always_comb begin
    nxt        = state;
    ld_main_in = 1'b0;
    ld_main_sk = 1'b0;
    ld_skid    = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          nxt        = ONE;
          ld_main_in = 1'b1;
        end
      end
      ONE: begin
        unique case (1'b1)
          (accept && drain): begin
            nxt        = ONE;
            ld_main_in = 1'b1;
          end
          (accept && !drain): begin
            nxt     = FULL;
            ld_skid = 1'b1;
          end
          (!accept && drain): begin
            nxt = EMPTY;
          end
          default: nxt = ONE;
        endcase
      end
      FULL: begin
        if (drain) begin
          nxt        = ONE;
          ld_main_sk = 1'b1;
        end
      end
      default: nxt = EMPTY;
    endcase
    // Flush empties the stage but leaves register contents alone.
    if (flush) begin
      nxt        = EMPTY;
      ld_main_in = 1'b0;
      ld_main_sk = 1'b0;
      ld_skid    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_in)      main_q <= in_word;
      else if (ld_main_sk) main_q <= skid_q;
      if (ld_skid)         skid_q <= in_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready
                 && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid.
// Second instance with CNT_W=4 checks stall counter saturation.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_tag;
  logic [1:0]  in_ra;
  logic [1:0]  in_rb;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_tag;
  logic [1:0]  out_ra;
  logic [1:0]  out_rb;
  logic [1:0]  occupancy;
  logic [7:0]  stall_cnt;

  logic        in_ready4;
  logic        out_valid4;
  logic [15:0] out_data4;
  logic [3:0]  out_tag4;
  logic [1:0]  out_ra4;
  logic [1:0]  out_rb4;
  logic [1:0]  occupancy4;
  logic [3:0]  stall_cnt4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_skid u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_tag(in_tag),
    .in_ra(in_ra), .in_rb(in_rb),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag),
    .out_ra(out_ra), .out_rb(out_rb),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_tag(in_tag),
    .in_ra(in_ra), .in_rb(in_rb),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .out_tag(out_tag4),
    .out_ra(out_ra4), .out_rb(out_rb4),
    .occupancy(occupancy4), .stall_cnt(stall_cnt4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d,
                      input logic [3:0] t);
    in_valid = 1'b1;
    in_data  = d;
    in_tag   = t;
  endtask

  task automatic pulse_rst();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_tag    = '0;
    in_ra     = 2'd1;
    in_rb     = 2'd2;
    out_ready = 1'b0;
    #2;
    chk("rst_ov", 32'(out_valid), 0);
    chk("rst_ir", 32'(in_ready), 1);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_sc", 32'(stall_cnt), 0);
    chk("rst_od", 32'(out_data), 0);
    step();
    rst_n = 1'b1;

    // single word latency
    push(16'hA55A, 4'h3);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat_ov", 32'(out_valid), 1);
    chk("lat_od", 32'(out_data), 32'hA55A);
    chk("lat_ot", 32'(out_tag), 3);
    chk("lat_ra", 32'(out_ra), 1);
    chk("lat_occ", 32'(occupancy), 1);
    step();
    chk("lat_ov0", 32'(out_valid), 0);

    // fill to FULL, then drain in order
    out_ready = 1'b0;
    push(16'h1111, 4'h1);
    step();
    push(16'h2222, 4'h2);
    step();
    in_valid = 1'b0;
    chk("full_occ", 32'(occupancy), 2);
    chk("full_ir", 32'(in_ready), 0);
    chk("full_od", 32'(out_data), 32'h1111);
    step();
    chk("hold_od", 32'(out_data), 32'h1111);
    chk("hold_ot", 32'(out_tag), 1);
    chk("hold_sc", 32'(stall_cnt), 2);
    out_ready = 1'b1;
    step();
    chk("dr1_ov", 32'(out_valid), 1);
    chk("dr1_od", 32'(out_data), 32'h2222);
    chk("dr1_occ", 32'(occupancy), 1);
    step();
    chk("dr2_ov", 32'(out_valid), 0);
    chk("dr2_occ", 32'(occupancy), 0);

    // streaming after a mid-cycle reset
    pulse_rst();
    chk("rst2_sc", 32'(stall_cnt), 0);
    for (int i = 0; i < 10; i++) begin
      push(16'h0100 + 16'(i), 4'(i));
      step();
      chk("str_od", 32'(out_data), 32'h0100 + i);
      chk("str_ir", 32'(in_ready), 1);
      chk("str_ov", 32'(out_valid), 1);
    end
    in_valid = 1'b0;
    step();
    chk("str_ov0", 32'(out_valid), 0);
    chk("str_sc", 32'(stall_cnt), 0);

    // flush while FULL with a word offered
    out_ready = 1'b0;
    push(16'h3333, 4'h4);
    step();
    push(16'h4444, 4'h5);
    step();
    chk("fl_pre", 32'(occupancy), 2);
    flush = 1'b1;
    push(16'h5555, 4'h6);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_ov", 32'(out_valid), 0);
    chk("fl_occ", 32'(occupancy), 0);
    chk("fl_ir", 32'(in_ready), 1);
    chk("fl_od", 32'(out_data), 32'h3333);
    out_ready = 1'b1;
    step();
    chk("fl_ov1", 32'(out_valid), 0);
    push(16'h6666, 4'h7);
    step();
    in_valid = 1'b0;
    chk("fl_nw", 32'(out_data), 32'h6666);
    step();
    chk("fl_end", 32'(out_valid), 0);

    // stall counter saturation
    pulse_rst();
    out_ready = 1'b0;
    push(16'h7777, 4'h8);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("sat4", 32'(stall_cnt4), 15);
    chk("cnt8", 32'(stall_cnt), 20);
    step();
    chk("sat4b", 32'(stall_cnt4), 15);
    chk("sat_od", 32'(out_data), 32'h7777);

    // reset while FULL
    push(16'h8888, 4'h9);
    step();
    in_valid = 1'b0;
    chk("r_full", 32'(occupancy), 2);
    rst_n = 1'b0;
    #1;
    chk("r_ov", 32'(out_valid), 0);
    chk("r_occ", 32'(occupancy), 0);
    chk("r_sc", 32'(stall_cnt), 0);
    chk("r_sc4", 32'(stall_cnt4), 0);
    chk("r_od", 32'(out_data), 0);
    chk("r_ir", 32'(in_ready), 1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    push(16'h9999, 4'hA);
    step();
    in_valid = 1'b0;
    chk("r_new", 32'(out_data), 32'h9999);
    chk("r_nocc", 32'(occupancy), 1);
    step();
    chk("r_end", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
